// File: rtl/collector_pkg.sv
// Shared constants and FSM state type for the skewed-matrix collector.
package collector_pkg;

    localparam int unsigned W     = 32;        // data word width (IEEE-754 single, stored bit-exact)
    localparam int unsigned N     = 4;         // matrix dimension and lane count
    localparam int unsigned BEATS = 2 * N - 1; // beats per skewed frame

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/collector_store.sv
// Matrix storage for the collector: decodes which lanes land on which
// element for a given beat of the skew, and serves combinational reads.
module collector_store #(
    parameter  int unsigned W  = collector_pkg::W,
    parameter  int unsigned N  = collector_pkg::N,
    localparam int unsigned BW = $clog2(2 * N - 1),
    localparam int unsigned AW = $clog2(N * N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [BW-1:0]       beat,
    input  logic [N-1:0][W-1:0] lanes,
    input  logic [AW-1:0]       rd_addr,
    output logic [W-1:0]        rd_data
);

    logic [W-1:0]  mat       [N*N];
    logic [N-1:0]  lane_we;
    logic [BW-1:0] lane_col  [N];
    logic [AW-1:0] lane_addr [N];

    // Lane i carries row i delayed by i beats; only columns 0..N-1 are real.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            lane_col[i]  = beat - BW'(i);
            lane_we[i]   = we && (beat >= BW'(i)) && (lane_col[i] < BW'(N));
            lane_addr[i] = AW'(i * int'(N)) + AW'(lane_col[i]);
        end
    end

    // Element storage; cleared on reset, written per enabled lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N * N); k++) begin
                mat[k] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (lane_we[i]) begin
                    mat[lane_addr[i]] <= lanes[i];
                end
            end
        end
    end

    assign rd_data = mat[rd_addr];

endmodule

// File: rtl/collector.sv
// Collects one skewed N x N frame from the dispatcher lanes into a matrix,
// holds it until the consumer releases it, and flags protocol errors.
// The consumer handshake port is named rel because release is a reserved word.
module collector #(
    parameter  int unsigned W  = collector_pkg::W,
    parameter  int unsigned N  = collector_pkg::N,
    localparam int unsigned AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d1,
    input  logic [W-1:0]  d2,
    input  logic [W-1:0]  d3,
    input  logic [W-1:0]  d4,
    input  logic          in_valid,
    input  logic          in_first,
    output logic          in_ready,
    output logic          done,
    output logic          full,
    input  logic          rel,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          frame_err
);

    import collector_pkg::*;

    localparam int unsigned   BW   = $clog2(2 * N - 1);
    localparam logic [BW-1:0] LAST = BW'(2 * N - 2);

    state_t              state_q;
    state_t              state_d;
    logic [BW-1:0]       beat_q;
    logic [BW-1:0]       beat_d;
    logic [BW-1:0]       wr_beat;
    logic                store_we;
    logic                err_set;
    logic                done_d;
    logic                accept;
    logic [N-1:0][W-1:0] lanes;

    assign lanes  = {d4, d3, d2, d1};
    assign accept = in_valid && in_ready;

    // Next-state, beat counter and store-write decode.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wr_beat  = beat_q;
        store_we = 1'b0;
        err_set  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_first) begin
                        store_we = 1'b1;
                        wr_beat  = '0;
                        beat_d   = BW'(1);
                        state_d  = COLLECT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    store_we = 1'b1;
                    if (in_first) begin
                        // Restart in place: earlier writes stay until overwritten.
                        err_set = 1'b1;
                        wr_beat = '0;
                        beat_d  = BW'(1);
                    end else if (beat_q == LAST) begin
                        state_d = FULL;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            FULL: begin
                if (rel) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            in_ready  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            done      <= done_d;
            full      <= (state_d == FULL);
            in_ready  <= (state_d != FULL);
            frame_err <= frame_err | err_set;
        end
    end

    collector_store #(
        .W (W),
        .N (N)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (store_we),
        .beat    (wr_beat),
        .lanes   (lanes),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/collector.md
COLLECTOR -- requirements
Module: collector

Interface
REQ-001 SHALL have parameter W, default 32, data word width (IEEE-754 single).
REQ-002 SHALL have parameter N, default 4, matrix dimension and lane count; beats per frame are 2N-1 = 7.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports d1, d2, d3, d4  input  W each  skewed lane data from the dispatcher; lane i carries row i.
REQ-006 SHALL have port in_valid  input  1  the lanes hold a beat this cycle.
REQ-007 SHALL have port in_first  input  1  marks beat 0 of a frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  the collector accepts a beat this cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the frame completes.
REQ-010 SHALL have port full  output  1  a complete matrix is held.
REQ-011 SHALL have port release  input  1  consumer has finished reading the matrix.
REQ-012 SHALL have port rd_addr  input  4  element index, row*N+col, 0-based.
REQ-013 SHALL have port rd_data  output  W  element at rd_addr.
REQ-014 SHALL have port frame_err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, COLLECT, FULL.
REQ-016 A beat SHALL be accepted when in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in IDLE and COLLECT, and 0 in FULL.
REQ-018 Beat counter b (0..2N-2) SHALL start at 0 and advance only on accepted beats; gap cycles (in_valid=0) hold all state.
REQ-019 On accepted beat b, lane i (1..N) SHALL write mat[i-1][b-(i-1)] only when 0 <= b-(i-1) <= N-1; lanes outside that window are ignored.
REQ-020 From IDLE, an accepted beat with in_first=1 SHALL go to COLLECT with b=1 after writing beat 0; an accepted beat with in_first=0 SHALL be dropped and set frame_err.
REQ-021 In COLLECT, an accepted beat with in_first=1 SHALL set frame_err and restart the frame as beat 0, keeping earlier writes until they are overwritten.
REQ-022 Accepting beat 2N-2 SHALL write the final element and enter FULL next cycle, with done=1 for exactly that cycle; latency is one cycle from the last beat to done/full.
REQ-023 full SHALL be 1 exactly while in FULL.
REQ-024 In FULL, release=1 SHALL return the FSM to IDLE with b=0; any beat presented in that same cycle is not accepted.
REQ-025 release outside FULL SHALL be ignored.
REQ-026 rd_data SHALL be combinational from mat[rd_addr] in every state.
REQ-027 No arithmetic SHALL be applied to the data: words are stored bit-exact; the block contains no float logic.

Reset
REQ-028 On rst=1 at a clock edge: FSM=IDLE, b=0, all mat entries=0, done=0, frame_err=0, full=0.
REQ-029 After reset, in_ready SHALL be 1.
REQ-030 Reset SHALL take priority over every other input, including mid-frame and in FULL.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, N, W and the BEATS=2N-1 constant.
REQ-032 The mat storage with its per-lane write-enable decode SHALL be one sub-module, collector_store; the FSM and counter SHALL stay in collector.

Verification
REQ-033 Integer ramp: r[i][j] = 4i+j skewed over 7 consecutive beats with in_first on beat 0 -> done pulses once, the cycle after beat 6; rd_addr k returns k for k = 0..15.
REQ-034 Float ramp: 0x00000000, 0x3f800000 ... 0x41700000 with idle gaps inserted between beats 2/3 and 5/6 -> identical matrix, done delayed only by the gap count.
REQ-035 Back-pressure: a second frame is driven while FULL -> in_ready=0 and the matrix is unchanged; after release, that frame is collected correctly.
REQ-036 in_first reasserted at beat 3 -> frame_err=1 and stays set; the restarted 7-beat frame completes with correct contents.
REQ-037 rst raised at beat 4 -> the next cycle shows IDLE, all reads return 0, done=0, frame_err=0; a fresh frame then completes normally.
REQ-038 release and in_valid both asserted in FULL -> the FSM goes to IDLE, the beat is not accepted, and frame_err is unchanged.
